// File: rtl/i2s_tdm_capture.sv
// I2S / left-justified / TDM capture front-end: oversamples the codec pads on AMSCK,
// deserialises NUM_CH slots per frame and hands each sample to its per-channel FIFO.
//  state   | meaning
//  IDLE    | capture disabled
//  WAIT_FS | waiting for a falling lrck (frame start)
//  SKIP    | I2S delay bclk between frame sync and MSB
//  SHIFT   | shifting slot bits MSB-first
`timescale 1ns/1ps
module i2s_tdm_capture #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int NUM_CH  = 2,
  parameter int JUSTIFY = 0,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              AMSCK,
  input  logic              aresetn,
  input  logic              enable,
  input  logic              bclk,
  input  logic              lrck,
  input  logic              sdin,
  input  logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic [NUM_CH-1:0] ovf_sticky,
  input  logic              ovf_clr,
  output logic [15:0]       drop_cnt,
  output logic              frame_err
);

  localparam int BIT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int SH_W  = (DATA_W > 1) ? DATA_W - 1 : 1;
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SLOT_W - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  if (DATA_W < 1 || DATA_W > SLOT_W) begin : g_bad_data_w
    $error("i2s_tdm_capture: DATA_W must be within 1..SLOT_W");
  end
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("i2s_tdm_capture: NUM_CH must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT_FS, SKIP, SHIFT} state_t;

  logic bclk_s1, bclk_s2, bclk_d;
  logic lrck_s1, lrck_s2, lrck_prev;
  logic sdin_s1, sdin_s2;
  logic tick, fs;

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [CH_W-1:0]  slot;
  logic [SH_W-1:0]  shift_q;
  logic [DATA_W-1:0] shift_nxt;

  logic             do_bit, last_bit, fs_err, emit, slot_end, frame_end;
  logic [BIT_W-1:0] bit_idx;
  logic [CH_W-1:0]  slot_idx;

  logic              drop;
  logic [NUM_CH-1:0] sticky_nxt;
  logic [15:0]       cnt_base, cnt_nxt;

  always_ff @(posedge AMSCK or negedge aresetn) begin
    if (!aresetn) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_d    <= 1'b0;
      lrck_s1   <= 1'b0;
      lrck_s2   <= 1'b0;
      lrck_prev <= 1'b0;
      sdin_s1   <= 1'b0;
      sdin_s2   <= 1'b0;
    end else begin
      bclk_s1 <= bclk;
      bclk_s2 <= bclk_s1;
      bclk_d  <= bclk_s2;
      lrck_s1 <= lrck;
      lrck_s2 <= lrck_s1;
      sdin_s1 <= sdin;
      sdin_s2 <= sdin_s1;
      if (tick) lrck_prev <= lrck_s2;
    end
  end

  assign tick = bclk_s2 & ~bclk_d;
  assign fs   = tick & lrck_prev & ~lrck_s2;

  if (DATA_W == 1) begin : g_shift_1
    assign shift_nxt = sdin_s2;
  end else begin : g_shift_n
    assign shift_nxt = {shift_q[DATA_W-2:0], sdin_s2};
  end

  assign last_bit = (bit_cnt == LAST_BIT) && (slot == LAST_CH);
  // In I2S the next frame's sync lands on the final (padding) bit of the last slot.
  assign fs_err = fs && ((state == SKIP) ||
                  ((state == SHIFT) && !((JUSTIFY == 0) && last_bit)));

  always_comb begin
    do_bit   = 1'b0;
    bit_idx  = bit_cnt;
    slot_idx = slot;
    if (tick) begin
      case (state)
        WAIT_FS: if (fs && (JUSTIFY != 0)) begin
          do_bit   = 1'b1;
          bit_idx  = '0;
          slot_idx = '0;
        end
        SKIP: if (!fs) begin
          do_bit  = 1'b1;
          bit_idx = '0;
        end
        SHIFT: begin
          if (!fs || ((JUSTIFY == 0) && last_bit)) begin
            do_bit = 1'b1;
          end else if (JUSTIFY != 0) begin
            do_bit   = 1'b1;
            bit_idx  = '0;
            slot_idx = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign emit      = do_bit && (bit_idx == LAST_DATA);
  assign slot_end  = do_bit && (bit_idx == LAST_BIT);
  assign frame_end = slot_end && (slot_idx == LAST_CH);

  always_ff @(posedge AMSCK or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      slot         <= '0;
      shift_q      <= '0;
      fifo_wr_data <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        bit_cnt <= '0;
        slot    <= '0;
      end else if (tick) begin
        if (state == IDLE) begin
          state <= WAIT_FS;
        end else begin
          frame_err <= fs_err;
          if (do_bit) begin
            shift_q <= shift_nxt[SH_W-1:0];
            if (emit) begin
              fifo_wr_data <= shift_nxt;
              sample_ch    <= slot_idx;
              sample_valid <= 1'b1;
            end
          end
          if (fs && (JUSTIFY == 0)) begin
            state   <= SKIP;
            bit_cnt <= '0;
            slot    <= '0;
          end else if (do_bit) begin
            if (frame_end) begin
              state   <= WAIT_FS;
              bit_cnt <= '0;
              slot    <= '0;
            end else if (slot_end) begin
              state   <= SHIFT;
              bit_cnt <= '0;
              slot    <= slot_idx + CH_W'(1);
            end else begin
              state   <= SHIFT;
              bit_cnt <= bit_idx + BIT_W'(1);
              slot    <= slot_idx;
            end
          end
        end
      end
    end
  end

  always_comb begin
    fifo_wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_wr_en[i] = sample_valid && (sample_ch == CH_W'(i)) && !fifo_full[i];
    end
  end

  assign drop = sample_valid && fifo_full[sample_ch];

  // A clear and a drop in the same cycle keep the drop.
  always_comb begin
    sticky_nxt = ovf_clr ? '0 : ovf_sticky;
    cnt_base   = ovf_clr ? 16'd0 : drop_cnt;
    cnt_nxt    = cnt_base;
    if (drop) begin
      sticky_nxt[sample_ch] = 1'b1;
      if (cnt_base != 16'hFFFF) cnt_nxt = cnt_base + 16'd1;
    end
  end

  always_ff @(posedge AMSCK or negedge aresetn) begin
    if (!aresetn) begin
      ovf_sticky <= '0;
      drop_cnt   <= '0;
    end else begin
      ovf_sticky <= sticky_nxt;
      drop_cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_tdm_capture.sv
// Directed bench: stereo I2S instance plus a 4-slot left-justified TDM instance.
`timescale 1ns/1ps
module tb_i2s_tdm_capture;

  logic AMSCK = 1'b0;
  always #5 AMSCK = ~AMSCK;

  logic        aresetn, enable, bclk, lrck, sdin, ovf_clr;
  logic [1:0]  fifo_full, fifo_wr_en, ovf_sticky;
  logic [23:0] fifo_wr_data;
  logic [0:0]  sample_ch;
  logic        sample_valid, frame_err;
  logic [15:0] drop_cnt;

  logic        t_enable, t_bclk, t_lrck, t_sdin, t_ovf_clr;
  logic [3:0]  t_fifo_full, t_fifo_wr_en, t_ovf_sticky;
  logic [23:0] t_fifo_wr_data;
  logic [1:0]  t_sample_ch;
  logic        t_sample_valid, t_frame_err;
  logic [15:0] t_drop_cnt;

  i2s_tdm_capture dut (
    .AMSCK(AMSCK), .aresetn(aresetn), .enable(enable), .bclk(bclk), .lrck(lrck),
    .sdin(sdin), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt), .frame_err(frame_err)
  );

  i2s_tdm_capture #(.DATA_W(24), .SLOT_W(32), .NUM_CH(4), .JUSTIFY(1)) dut_tdm (
    .AMSCK(AMSCK), .aresetn(aresetn), .enable(t_enable), .bclk(t_bclk), .lrck(t_lrck),
    .sdin(t_sdin), .fifo_full(t_fifo_full), .fifo_wr_en(t_fifo_wr_en),
    .fifo_wr_data(t_fifo_wr_data), .sample_ch(t_sample_ch), .sample_valid(t_sample_valid),
    .ovf_sticky(t_ovf_sticky), .ovf_clr(t_ovf_clr), .drop_cnt(t_drop_cnt),
    .frame_err(t_frame_err)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] q_data[$];
  int          q_ch[$];
  logic [1:0]  q_wren[$];
  logic [23:0] t_q_data[$];
  int          t_q_ch[$];
  int          wren1_seen = 0;
  int          ferr_cnt = 0;
  int          t_ferr_cnt = 0;

  always @(negedge AMSCK) begin
    if (sample_valid) begin
      q_data.push_back(fifo_wr_data);
      q_ch.push_back(int'(sample_ch));
      q_wren.push_back(fifo_wr_en);
    end
    if (fifo_wr_en[1]) wren1_seen++;
    if (frame_err) ferr_cnt++;
    if (t_sample_valid) begin
      t_q_data.push_back(t_fifo_wr_data);
      t_q_ch.push_back(int'(t_sample_ch));
    end
    if (t_frame_err) t_ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sample(input string tag, input int ch, input logic [23:0] data,
                              input logic [1:0] wren);
    check({tag, "_present"}, 32'(q_data.size() != 0), 32'd1);
    if (q_data.size() != 0) begin
      check({tag, "_ch"}, 32'(q_ch.pop_front()), 32'(ch));
      check({tag, "_data"}, 32'(q_data.pop_front()), 32'(data));
      check({tag, "_wren"}, 32'(q_wren.pop_front()), 32'(wren));
    end
  endtask

  task automatic check_tdm(input string tag, input int ch, input logic [23:0] data);
    check({tag, "_present"}, 32'(t_q_data.size() != 0), 32'd1);
    if (t_q_data.size() != 0) begin
      check({tag, "_ch"}, 32'(t_q_ch.pop_front()), 32'(ch));
      check({tag, "_data"}, 32'(t_q_data.pop_front()), 32'(data));
    end
  endtask

  task automatic clear_q();
    q_data.delete();
    q_ch.delete();
    q_wren.delete();
  endtask

  task automatic bclk_cycle(input logic lr, input logic d);
    bclk = 1'b0; lrck = lr; sdin = d;
    repeat (4) @(negedge AMSCK);
    bclk = 1'b1;
    repeat (4) @(negedge AMSCK);
  endtask

  task automatic t_bclk_cycle(input logic lr, input logic d);
    t_bclk = 1'b0; t_lrck = lr; t_sdin = d;
    repeat (4) @(negedge AMSCK);
    t_bclk = 1'b1;
    repeat (4) @(negedge AMSCK);
  endtask

  task automatic idle_bclks(input int n);
    for (int i = 0; i < n; i++) bclk_cycle(1'b1, 1'b0);
  endtask

  // Bclks k_first..k_last of a 64-bclk I2S frame: lrck low for k<32, data one bclk late.
  task automatic i2s_frame(input logic [23:0] l, input logic [23:0] r,
                           input int k_first, input int k_last);
    logic [31:0] wl, wr;
    logic d;
    wl = {l, 8'h00};
    wr = {r, 8'h00};
    for (int k = k_first; k <= k_last; k++) begin
      if (k == 0) d = 1'b0;
      else if (k <= 32) d = wl[32-k];
      else d = wr[64-k];
      bclk_cycle(k >= 32, d);
    end
  endtask

  task automatic tdm_frame(input logic [23:0] s0, input logic [23:0] s1,
                           input logic [23:0] s2, input logic [23:0] s3);
    logic [31:0] w [4];
    w[0] = {s0, 8'h00}; w[1] = {s1, 8'h00}; w[2] = {s2, 8'h00}; w[3] = {s3, 8'h00};
    for (int k = 0; k < 128; k++) begin
      t_bclk_cycle(k >= 64, w[k/32][31-(k%32)]);
    end
  endtask

  initial begin
    bit clr_hit;
    aresetn = 1'b0; enable = 1'b1; bclk = 1'b1; lrck = 1'b1; sdin = 1'b0;
    fifo_full = 2'b00; ovf_clr = 1'b0;
    t_enable = 1'b1; t_bclk = 1'b1; t_lrck = 1'b1; t_sdin = 1'b0;
    t_fifo_full = 4'h0; t_ovf_clr = 1'b0;

    // 1) reset with an active bit clock
    for (int i = 0; i < 6; i++) bclk_cycle(1'($urandom), 1'($urandom));
    check("rst_valid_seen", 32'(q_data.size()), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    check("rst_sample_ch", 32'(sample_ch), 32'd0);
    check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_tdm_valid", 32'(t_sample_valid), 32'd0);
    @(negedge AMSCK);
    aresetn = 1'b1;
    idle_bclks(3);

    // 2) stereo I2S frame
    clear_q();
    i2s_frame(24'hA5A5A5, 24'h123456, 0, 63);
    idle_bclks(2);
    check("i2s_count", 32'(q_data.size()), 32'd2);
    check_sample("i2s_left", 0, 24'hA5A5A5, 2'b01);
    check_sample("i2s_right", 1, 24'h123456, 2'b10);
    check("i2s_drop_cnt", 32'(drop_cnt), 32'd0);
    check("i2s_frame_err", 32'(ferr_cnt), 32'd0);

    // 3) left-justified 4-slot TDM, two back-to-back frames
    for (int i = 0; i < 3; i++) t_bclk_cycle(1'b1, 1'b0);
    tdm_frame(24'h000001, 24'h000002, 24'h000003, 24'h000004);
    tdm_frame(24'hFEDCBA, 24'h000000, 24'h800001, 24'h7FFFFF);
    for (int i = 0; i < 2; i++) t_bclk_cycle(1'b1, 1'b0);
    check("tdm_count", 32'(t_q_data.size()), 32'd8);
    check_tdm("tdm_f0_s0", 0, 24'h000001);
    check_tdm("tdm_f0_s1", 1, 24'h000002);
    check_tdm("tdm_f0_s2", 2, 24'h000003);
    check_tdm("tdm_f0_s3", 3, 24'h000004);
    check_tdm("tdm_f1_s0", 0, 24'hFEDCBA);
    check_tdm("tdm_f1_s1", 1, 24'h000000);
    check_tdm("tdm_f1_s2", 2, 24'h800001);
    check_tdm("tdm_f1_s3", 3, 24'h7FFFFF);
    check("tdm_frame_err", 32'(t_ferr_cnt), 32'd0);
    check("tdm_drop_cnt", 32'(t_drop_cnt), 32'd0);

    // 4) channel 1 FIFO full for three frames, then clear coinciding with a drop
    clear_q();
    wren1_seen = 0;
    fifo_full = 2'b10;
    i2s_frame(24'h111111, 24'h222222, 0, 63);
    i2s_frame(24'h333333, 24'h444444, 0, 63);
    i2s_frame(24'h555555, 24'h666666, 0, 63);
    idle_bclks(2);
    check("ovf_count", 32'(q_data.size()), 32'd6);
    check_sample("ovf_f0_l", 0, 24'h111111, 2'b01);
    check_sample("ovf_f0_r", 1, 24'h222222, 2'b00);
    check("ovf_wren1_seen", 32'(wren1_seen), 32'd0);
    check("ovf_sticky3", 32'(ovf_sticky), 32'h2);
    check("ovf_drop_cnt3", 32'(drop_cnt), 32'd3);
    clr_hit = 1'b0;
    fork
      i2s_frame(24'h777777, 24'h888888, 0, 63);
      begin
        for (int n = 0; n < 1000 && !clr_hit; n++) begin
          @(negedge AMSCK);
          if (sample_valid && sample_ch == 1'b1) clr_hit = 1'b1;
        end
        if (clr_hit) begin
          ovf_clr = 1'b1;
          @(negedge AMSCK);
          ovf_clr = 1'b0;
        end
      end
    join
    check("clr_drop_seen", 32'(clr_hit), 32'd1);
    check("clr_sticky", 32'(ovf_sticky), 32'h2);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
    fifo_full = 2'b00;
    idle_bclks(2);

    // 5) early frame sync at bit 10 of slot 1, then a clean frame
    clear_q();
    ferr_cnt = 0;
    i2s_frame(24'hCAFE01, 24'hBEEF02, 0, 42);
    i2s_frame(24'h13579B, 24'h2468AC, 0, 63);
    idle_bclks(2);
    check("ferr_pulses", 32'(ferr_cnt), 32'd1);
    check("ferr_count", 32'(q_data.size()), 32'd3);
    check_sample("ferr_partial_l", 0, 24'hCAFE01, 2'b01);
    check_sample("ferr_next_l", 0, 24'h13579B, 2'b01);
    check_sample("ferr_next_r", 1, 24'h2468AC, 2'b10);

    // 6) enable dropped mid-slot 0 for 5 bclks
    clear_q();
    i2s_frame(24'hDEAD00, 24'hF00D00, 0, 9);
    enable = 1'b0;
    i2s_frame(24'hDEAD00, 24'hF00D00, 10, 14);
    enable = 1'b1;
    i2s_frame(24'hDEAD00, 24'hF00D00, 15, 63);
    check("en_no_valid", 32'(q_data.size()), 32'd0);
    i2s_frame(24'h0F0F0F, 24'hF0F0F0, 0, 63);
    idle_bclks(2);
    check("en_count", 32'(q_data.size()), 32'd2);
    check_sample("en_left", 0, 24'h0F0F0F, 2'b01);
    check_sample("en_right", 1, 24'hF0F0F0, 2'b10);

    // drop counter saturation, preloaded near the top
    force dut.drop_cnt = 16'hFFFE;
    repeat (2) @(negedge AMSCK);
    release dut.drop_cnt;
    fifo_full = 2'b01;
    i2s_frame(24'h010203, 24'h040506, 0, 63);
    idle_bclks(1);
    check("sat_drop_cnt_1", 32'(drop_cnt), 32'hFFFF);
    i2s_frame(24'h070809, 24'h0A0B0C, 0, 63);
    idle_bclks(1);
    check("sat_drop_cnt_2", 32'(drop_cnt), 32'hFFFF);
    check("sat_sticky", 32'(ovf_sticky), 32'h3);
    fifo_full = 2'b00;
    ovf_clr = 1'b1;
    @(negedge AMSCK);
    ovf_clr = 1'b0;
    @(negedge AMSCK);
    check("clr_only_drop_cnt", 32'(drop_cnt), 32'd0);
    check("clr_only_sticky", 32'(ovf_sticky), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
